// File: rtl/seq_divider.sv
// seq_divider: iterative WIDTH-bit restoring divider with RV32M
// DIV/DIVU/REM/REMU semantics, one quotient bit per clock.
//
// Handshake: i_start is sampled only in IDLE together with i_signed,
// op_a and op_b. The unit is then busy (o_busy=1) through CALC and FIX.
// o_done pulses for exactly one cycle in DONE, and the results are already
// valid in that cycle. A start seen outside IDLE is dropped. There is no
// back-pressure: done is not held waiting for an acknowledge.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_start      start request (IDLE only)
//   i_signed     1 = DIV/REM, 0 = DIVU/REMU
//   op_a, op_b   dividend, divisor
//   o_busy       high in CALC and FIX
//   o_done       one-cycle completion pulse
//   o_quotient   registered quotient, held until the next FIX
//   o_remainder  registered remainder, held until the next FIX
//   o_state      current FSM state, for debug observation

// Plain ripple-carry adder, used here as a subtractor (inverted op_b, cin=1).
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = op_a[i] ^ op_b[i] ^ c;
      c      = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    cout = c;
  end
endmodule

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic [1:0]       o_state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] r_reg;    // partial remainder
  logic [WIDTH-1:0] q_reg;    // dividend magnitude shifting out, quotient in
  logic [WIDTH-1:0] dvsr;     // divisor magnitude
  logic [WIDTH-1:0] a_raw;    // untouched dividend, returned on divide by zero
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             div0;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] diff;
  logic             diff_cout;
  logic             no_borrow;

  // Magnitudes at sampling time. 0x80000000 maps onto itself, which gives
  // the RV32M overflow result without needing a special path.
  assign a_mag = (i_signed && op_a[WIDTH-1]) ? (~op_a + ONE) : op_a;
  assign b_mag = (i_signed && op_b[WIDTH-1]) ? (~op_b + ONE) : op_b;

  // The shifted remainder is WIDTH+1 bits wide: {r_reg[WIDTH-1], r_shift}.
  // Only the low WIDTH bits go through the adder. The subtraction of the
  // full value has no borrow if the dropped top bit is set or the low part
  // carries out. A non-borrowing result is less than the divisor, so it
  // always fits back into WIDTH bits.
  assign r_shift = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

  adder #(.WIDTH(WIDTH)) u_sub (
    .op_a (r_shift),
    .op_b (~dvsr),
    .cin  (1'b1),
    .sum  (diff),
    .cout (diff_cout)
  );

  assign no_borrow = r_reg[WIDTH-1] | diff_cout;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_next = S_CALC;
      end
      S_CALC: begin
        o_busy = 1'b1;
        if (cnt == LAST_CNT) state_next = S_FIX;
      end
      S_FIX: begin
        o_busy     = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_state = state;

  // Datapath
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_reg       <= '0;
      q_reg       <= '0;
      dvsr        <= '0;
      a_raw       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div0        <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            q_reg <= a_mag;
            dvsr  <= b_mag;
            a_raw <= op_a;
            r_reg <= '0;
            cnt   <= '0;
            neg_q <= i_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r <= i_signed & op_a[WIDTH-1];
            div0  <= (op_b == '0);
          end
        end
        S_CALC: begin
          r_reg <= no_borrow ? diff : r_shift;
          q_reg <= {q_reg[WIDTH-2:0], no_borrow};
          cnt   <= cnt + CW'(1);
        end
        S_FIX: begin
          if (div0) begin
            o_quotient  <= '1;
            o_remainder <= a_raw;
          end else begin
            o_quotient  <= neg_q ? (~q_reg + ONE) : q_reg;
            o_remainder <= neg_r ? (~r_reg + ONE) : r_reg;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed vectors with hand-computed results.
// The driver pushes the expected quotient, remainder and start edge into
// queues. A negedge monitor pops them whenever o_done is seen and checks
// the values, the latency and the busy-cycle count.
module tb_seq_divider;
  localparam int W = 32;

  logic         i_clk;
  logic         i_reset;
  logic         i_start;
  logic         i_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic [1:0]   o_state;

  seq_divider #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_state     (o_state)
  );

  // ---------------- clock / reset / edge counter ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic [W-1:0] exp_t_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge i_clk) begin
    if (!i_reset) begin
      busy_cnt = 0;
    end else begin
      if (o_busy) busy_cnt++;
      if (o_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done at edge %0d expected none", cyc);
        end else begin
          logic [W-1:0] eq, er, et;
          eq = exp_q.pop_front();
          er = exp_r_q.pop_front();
          et = exp_t_q.pop_front();
          check("quotient", o_quotient, eq);
          check("remainder", o_remainder, er);
          check("done_latency", W'(cyc), et + W'(33));
          check("busy_cycles", W'(busy_cnt), W'(33));
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er);
    @(negedge i_clk);
    i_signed = s;
    op_a     = a;
    op_b     = b;
    i_start  = 1'b1;
    exp_q.push_back(eq);
    exp_r_q.push_back(er);
    exp_t_q.push_back(W'(cyc + 1));
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic pulse_junk();
    @(negedge i_clk);
    i_signed = 1'b1;
    op_a     = 32'd5;
    op_b     = 32'd5;
    i_start  = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      #1;
      if (!o_busy && !o_done && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle",
               o_busy, exp_q.size());
      exp_q.delete();
      exp_r_q.delete();
      exp_t_q.delete();
    end
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er);
    start_op(s, a, b, eq, er);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_reset  = 1'b0;
    i_start  = 1'b0;
    i_signed = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (2) @(negedge i_clk);
    check("reset_busy", W'(o_busy), '0);
    check("reset_done", W'(o_done), '0);
    check("reset_quotient", o_quotient, '0);
    check("reset_remainder", o_remainder, '0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Unsigned and signed basics
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    // Divide by zero
    run_op(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);
    run_op(1'b0, 32'd123, 32'd0, 32'hFFFFFFFF, 32'd123);
    // Overflow operands, both signednesses
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

    // Ignored starts at k+5, k+33 (FIX) and k+34 (DONE), then an accepted
    // start in the first IDLE cycle (k+35).
    start_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    repeat (4) @(negedge i_clk);
    pulse_junk();
    repeat (27) @(negedge i_clk);
    pulse_junk();
    pulse_junk();
    start_op(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
    wait_idle();

    // Asynchronous reset in the middle of CALC
    start_op(1'b0, 32'd12345, 32'd6, 32'd2057, 32'd3);
    repeat (10) @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    check("abort_busy", W'(o_busy), '0);
    check("abort_done", W'(o_done), '0);
    check("abort_quotient", o_quotient, '0);
    check("abort_remainder", o_remainder, '0);
    void'(exp_q.pop_back());
    void'(exp_r_q.pop_back());
    void'(exp_t_q.pop_back());
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (40) @(negedge i_clk);
    run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
